band_out_serializer: RTL and testbench
======================================

Name: band_out_serializer

Overview:
- Sits directly downstream of the 16-band filterbank core.
- On each band-frame strobe, captures all 16 band outputs (sfix31), rounds and saturates each to OUT_W bits, and streams them out one band per transfer over a valid/ready interface.
- Double-buffered (pending + active frame) so a new frame can land while the previous one drains; dropped frames are flagged.

Parameters:
- NBANDS, 16, number of filter bands per frame (fixed at 16 for band index width 4)
- IN_W, 31, input band sample width (signed)
- DROP, 15, LSBs removed by rounding; must satisfy 1 <= DROP < IN_W
- OUT_W, 16, output sample width (signed); must satisfy OUT_W <= IN_W-DROP+1

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clk_enable  in  1  global enable; 0 freezes all state, outputs hold, out_ready ignored
- frame_valid  in  1  one-cycle strobe: band_in holds a complete new frame
- band_in  in  [NBANDS] x IN_W  unpacked array of signed band samples, index 0 = band 0
- out_valid  out  1  out_data/out_band/out_last valid
- out_ready  in  1  consumer accepts when out_valid && out_ready && clk_enable
- out_data  out  OUT_W  rounded/saturated band sample (signed)
- out_band  out  4  band index of out_data
- out_last  out  1  high with band NBANDS-1
- overrun  out  1  sticky: a frame was dropped
- overrun_clr  in  1  clears overrun (lower priority than a same-cycle set)
- drop_count  out  8  frames dropped, saturates at 255, cleared by overrun_clr

Behaviour:
- Reset (async, active-high): out_valid=0, out_data=0, out_band=0, out_last=0, overrun=0, drop_count=0, pending_full=0, state=IDLE. All buffer contents cleared.
- Every update below requires clk_enable=1.
- Capture: frame_valid with pending empty, or with pending vacating this cycle, loads all 16 samples into pending and sets pending_full.
- Drop: frame_valid with pending full and not vacating drops the frame, sets overrun, and increments drop_count (saturating at 255). If overrun_clr is asserted in the same cycle, the set wins and drop_count becomes 1.
- Conversion is applied at pending load, so the buffer stores OUT_W-bit values:
  - r = x + 2^(DROP-1), computed at IN_W+1 bits, then arithmetic shift right by DROP.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- State IDLE: if pending_full, transfer pending to active, clear pending_full (vacating), and go to SEND with index 0. out_valid rises the following cycle.
- Latency: frame_valid at edge N (idle, empty) gives first out_valid=1 after edge N+2.
- State SEND: presents active[index], with out_band=index and out_last=(index==15).
  - On a handshake with index<15: index increments.
  - On a handshake with index==15: if pending_full, transfer immediately and stay in SEND at index 0 (no bubble); otherwise out_valid=0 and return to IDLE.
- Stability: while out_valid && !out_ready, out_data/out_band/out_last hold.
- out_valid never drops without a handshake, except on reset.
- Reset mid-frame discards both buffers and any in-flight band.

Decomposition:
- Shared package filterbank_pkg holds:
  - NBANDS, IN_W, OUT_W, DROP defaults
  - band_sample_t (logic signed [IN_W-1:0])
  - out_sample_t
  - state enum {IDLE, SEND}
- One sub-module, round_sat: combinational IN_W to OUT_W round-half-up and saturate, instantiated NBANDS times at the pending load.

Test Plan:
- Single frame:
  - Stimulus: band_in[k]=k*32768, frame_valid pulse, out_ready=1.
  - Response: 16 transfers, out_data=k, out_band=k, out_last only at k=15; first out_valid 2 cycles after the strobe.
- Rounding/saturation:
  - Stimulus: 16383 → 0; 16384 → 1; -16385 → -1; 2^30-1 → 32767; -2^30 → -32768.
- Backpressure:
  - Stimulus: out_ready toggled randomly.
  - Response: out_data/out_band stable while stalled; no band lost or duplicated; sequence 0..15 intact.
- Back-to-back:
  - Stimulus: second frame_valid during band 5 of frame 1.
  - Response: frame 2 band 0 follows frame 1 band 15 in the next cycle (no bubble); overrun=0.
- Overrun:
  - Stimulus: out_ready=0, three frame_valid pulses.
  - Response: overrun=1, drop_count=1; after overrun_clr, overrun=0 and drop_count=0.
- Reset mid-stream:
  - Stimulus: assert reset during band 7 (async, between edges).
  - Response: out_valid=0 immediately; no residual bands after release until a new frame_valid.

Source files
------------

// File: rtl/filterbank_pkg.sv
// Shared types and default widths for the 16-band filterbank and its output serializer.
package filterbank_pkg;
  localparam int NBANDS = 16;
  localparam int IN_W   = 31;
  localparam int DROP   = 15;
  localparam int OUT_W  = 16;

  typedef logic signed [IN_W-1:0]  band_sample_t;
  typedef logic signed [OUT_W-1:0] out_sample_t;

  typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/round_sat.sv
// Combinational round-half-up by DROP LSBs followed by saturation to OUT_W signed bits.
module round_sat #(
  parameter int IN_W  = filterbank_pkg::IN_W,
  parameter int OUT_W = filterbank_pkg::OUT_W,
  parameter int DROP  = filterbank_pkg::DROP
) (
  input  logic signed [IN_W-1:0]  x,
  output logic signed [OUT_W-1:0] y
);
  localparam int SW = IN_W + 1 - DROP;
  localparam logic signed [IN_W:0] HALF = (IN_W+1)'(1) <<< (DROP - 1);

  // One guard bit above the input keeps the +half from wrapping at the positive limit.
  function automatic logic signed [SW-1:0] round_half_up(input logic signed [IN_W-1:0] v);
    logic signed [IN_W:0] r;
    r = (IN_W+1)'(v) + HALF;
    return r[IN_W:DROP];
  endfunction

  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [SW-1:0] v);
    logic [SW-OUT_W:0] top;
    top = v[SW-1:OUT_W-1];
    if (&top || ~|top) return v[OUT_W-1:0];
    else if (v[SW-1])  return {1'b1, {(OUT_W-1){1'b0}}};
    else               return {1'b0, {(OUT_W-1){1'b1}}};
  endfunction

  assign y = saturate(round_half_up(x));
endmodule

// File: rtl/band_out_serializer.sv
// Captures a full filterbank frame, converts it to OUT_W samples and streams one band per
// valid/ready transfer, with a pending buffer so the next frame can land while one drains.
module band_out_serializer #(
  parameter int NBANDS = filterbank_pkg::NBANDS,
  parameter int IN_W   = filterbank_pkg::IN_W,
  parameter int DROP   = filterbank_pkg::DROP,
  parameter int OUT_W  = filterbank_pkg::OUT_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clk_enable,
  input  logic                    frame_valid,
  input  logic signed [IN_W-1:0]  band_in [NBANDS],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic [3:0]              out_band,
  output logic                    out_last,
  output logic                    overrun,
  input  logic                    overrun_clr,
  output logic [7:0]              drop_count
);
  import filterbank_pkg::*;

  localparam logic [3:0] LAST = 4'(NBANDS - 1);

  logic signed [OUT_W-1:0] conv   [NBANDS];
  logic signed [OUT_W-1:0] pend_q [NBANDS];
  logic signed [OUT_W-1:0] pend_d [NBANDS];
  logic signed [OUT_W-1:0] act_q  [NBANDS];
  logic signed [OUT_W-1:0] act_d  [NBANDS];
  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       vld_q, vld_d;
  logic       pfull_q, pfull_d;
  logic       overrun_q, overrun_d;
  logic [7:0] drop_count_q, drop_count_d;
  logic       vacate, hs, drop;

  for (genvar k = 0; k < NBANDS; k++) begin : g_rs
    round_sat #(.IN_W(IN_W), .OUT_W(OUT_W), .DROP(DROP)) u_rs (
      .x (band_in[k]),
      .y (conv[k])
    );
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    vld_d        = vld_q;
    pfull_d      = pfull_q;
    pend_d       = pend_q;
    act_d        = act_q;
    overrun_d    = overrun_q;
    drop_count_d = drop_count_q;
    vacate       = 1'b0;
    drop         = 1'b0;
    hs           = vld_q && out_ready && clk_enable;

    if (clk_enable) begin
      case (state_q)
        IDLE: begin
          if (pfull_q) begin
            act_d   = pend_q;
            vacate  = 1'b1;
            idx_d   = '0;
            state_d = SEND;
          end
        end
        SEND: begin
          // First SEND cycle after a transfer from IDLE only raises out_valid.
          if (!vld_q) begin
            vld_d = 1'b1;
          end else if (hs) begin
            if (idx_q != LAST) begin
              idx_d = idx_q + 4'd1;
            end else if (pfull_q) begin
              act_d  = pend_q;
              vacate = 1'b1;
              idx_d  = '0;
            end else begin
              vld_d   = 1'b0;
              idx_d   = '0;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      if (vacate) pfull_d = 1'b0;

      if (frame_valid) begin
        if (!pfull_q || vacate) begin
          pend_d  = conv;
          pfull_d = 1'b1;
        end else begin
          drop = 1'b1;
        end
      end

      // A drop in the same cycle as a clear wins; the clear still restarts the count.
      if (drop) begin
        overrun_d = 1'b1;
        if (overrun_clr)                drop_count_d = 8'd1;
        else if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
      end else if (overrun_clr) begin
        overrun_d    = 1'b0;
        drop_count_d = '0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      vld_q        <= 1'b0;
      pfull_q      <= 1'b0;
      overrun_q    <= 1'b0;
      drop_count_q <= '0;
      for (int k = 0; k < NBANDS; k++) begin
        pend_q[k] <= '0;
        act_q[k]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      vld_q        <= vld_d;
      pfull_q      <= pfull_d;
      overrun_q    <= overrun_d;
      drop_count_q <= drop_count_d;
      pend_q       <= pend_d;
      act_q        <= act_d;
    end
  end

  assign out_valid  = vld_q;
  assign out_data   = act_q[idx_q];
  assign out_band   = idx_q;
  assign out_last   = vld_q && (idx_q == LAST);
  assign overrun    = overrun_q;
  assign drop_count = drop_count_q;
endmodule

// File: tb/tb_band_out_serializer.sv
// Directed bench for band_out_serializer: latency, rounding, backpressure, chaining, overrun, reset.
module tb_band_out_serializer;
  logic clock = 1'b0;
  logic reset, clk_enable, frame_valid, out_ready, overrun_clr;
  logic signed [30:0] band_in [16];
  logic out_valid, out_last, overrun;
  logic signed [15:0] out_data;
  logic [3:0] out_band;
  logic [7:0] drop_count;
  int total = 0;
  int passed = 0;

  always #5 clock = ~clock;

  band_out_serializer dut (
    .clock       (clock),
    .reset       (reset),
    .clk_enable  (clk_enable),
    .frame_valid (frame_valid),
    .band_in     (band_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_band    (out_band),
    .out_last    (out_last),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .drop_count  (drop_count)
  );

  task automatic load_ramp(input int mul, input int off);
    for (int k = 0; k < 16; k++) band_in[k] = 31'((k * mul + off) * 32768);
  endtask

  task automatic pulse_frame();
    frame_valid = 1'b1;
    @(negedge clock);
    frame_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; clk_enable = 1'b1; frame_valid = 1'b0; out_ready = 1'b0; overrun_clr = 1'b0;
    for (int k = 0; k < 16; k++) band_in[k] = '0;
    repeat (2) @(negedge clock);
    total++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || overrun !== 1'b0 || out_data !== 16'sd0 ||
        out_band !== 4'd0 || drop_count !== 8'd0)
      $display("FAIL reset_state: valid=%b last=%b ovr=%b data=%0d band=%0d drops=%0d, want all 0",
               out_valid, out_last, overrun, out_data, out_band, drop_count);
    else passed++;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    total++;
    if (out_valid !== 1'b0) $display("FAIL idle_after_reset: valid=%b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_single_frame();
    load_ramp(1, 0);
    out_ready = 1'b1;
    pulse_frame();
    total++;
    if (out_valid !== 1'b0) $display("FAIL latency_edge1: valid=%b want 0", out_valid); else passed++;
    @(negedge clock);
    total++;
    if (out_valid !== 1'b0) $display("FAIL latency_edge2: valid=%b want 0", out_valid); else passed++;
    @(negedge clock);
    for (int k = 0; k < 16; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 16'(k) || out_band !== 4'(k) || out_last !== (k == 15))
        $display("FAIL single_band%0d: valid=%b data=%0d band=%0d last=%b want 1 %0d %0d %b",
                 k, out_valid, out_data, out_band, out_last, k, k, (k == 15));
      else passed++;
      @(negedge clock);
    end
    total++;
    if (out_valid !== 1'b0) $display("FAIL single_end_valid: valid=%b want 0", out_valid); else passed++;
  endtask

  task automatic test_round_sat();
    logic signed [15:0] exp_v [16];
    for (int k = 0; k < 16; k++) begin band_in[k] = '0; exp_v[k] = '0; end
    band_in[0] = 31'sd16383;      exp_v[0] = 16'sd0;
    band_in[1] = 31'sd16384;      exp_v[1] = 16'sd1;
    band_in[2] = -31'sd16385;     exp_v[2] = -16'sd1;
    band_in[3] = 31'sd1073741823; exp_v[3] = 16'sd32767;
    band_in[4] = {1'b1, 30'd0};   exp_v[4] = {1'b1, 15'd0};
    band_in[5] = -31'sd16384;     exp_v[5] = 16'sd0;
    out_ready = 1'b1;
    pulse_frame();
    repeat (2) @(negedge clock);
    for (int k = 0; k < 16; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_v[k])
        $display("FAIL round_sat_band%0d: valid=%b data=%0d want 1 %0d", k, out_valid, out_data, exp_v[k]);
      else passed++;
      @(negedge clock);
    end
  endtask

  task automatic test_enable();
    bit drained;
    load_ramp(1, 0);
    out_ready = 1'b1;
    pulse_frame();
    repeat (4) @(negedge clock);
    clk_enable = 1'b0;
    repeat (3) @(negedge clock);
    total++;
    if (out_valid !== 1'b1 || out_band !== 4'd2 || out_data !== 16'sd2)
      $display("FAIL enable_freeze: valid=%b band=%0d data=%0d want 1 2 2", out_valid, out_band, out_data);
    else passed++;
    clk_enable = 1'b1;
    @(negedge clock);
    total++;
    if (out_band !== 4'd3) $display("FAIL enable_resume: band=%0d want 3", out_band); else passed++;
    drained = 1'b0;
    for (int c = 0; c < 40 && !drained; c++) begin
      if (!out_valid) drained = 1'b1;
      else @(negedge clock);
    end
    total++;
    if (!drained) $display("FAIL enable_drain: valid=%b want 0 within 40 cycles", out_valid); else passed++;
  endtask

  task automatic test_backpressure();
    int got;
    bit prev_stall;
    logic signed [15:0] pd;
    logic [3:0] pb;
    load_ramp(3, 7);
    out_ready = 1'b0;
    pulse_frame();
    got = 0; prev_stall = 1'b0; pd = '0; pb = '0;
    for (int c = 0; c < 400 && got < 16; c++) begin
      if (prev_stall) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== pd || out_band !== pb)
          $display("FAIL bp_stable: valid=%b data=%0d band=%0d want 1 %0d %0d", out_valid, out_data, out_band, pd, pb);
        else passed++;
      end
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        total++;
        if (out_band !== 4'(got) || out_data !== 16'(3 * got + 7))
          $display("FAIL bp_seq: band=%0d data=%0d want %0d %0d", out_band, out_data, got, 3 * got + 7);
        else passed++;
        got++;
      end
      prev_stall = out_valid && !out_ready;
      pd = out_data; pb = out_band;
      @(negedge clock);
    end
    total++;
    if (got != 16) $display("FAIL bp_count: transfers=%0d want 16", got); else passed++;
    out_ready = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    int got, bad;
    bit sent;
    int cyc [32];
    logic signed [15:0] d [32];
    load_ramp(1, 0);
    out_ready = 1'b1;
    frame_valid = 1'b1;
    @(negedge clock);
    got = 0; sent = 1'b0;
    for (int c = 0; c < 200 && got < 32; c++) begin
      frame_valid = 1'b0;
      if (out_valid) begin d[got] = out_data; cyc[got] = c; got++; end
      if (got == 6 && !sent) begin
        load_ramp(1, 100);
        frame_valid = 1'b1;
        sent = 1'b1;
      end
      @(negedge clock);
    end
    frame_valid = 1'b0;
    total++;
    if (got != 32) $display("FAIL b2b_count: transfers=%0d want 32", got); else passed++;
    if (got == 32) begin
      total++;
      if (cyc[16] != cyc[15] + 1) $display("FAIL b2b_bubble: gap=%0d want 1", cyc[16] - cyc[15]);
      else passed++;
      bad = 0;
      for (int k = 0; k < 32; k++) if (d[k] !== 16'((k < 16) ? k : k - 16 + 100)) bad++;
      total++;
      if (bad != 0) $display("FAIL b2b_data: wrong samples=%0d want 0", bad); else passed++;
    end
    total++;
    if (overrun !== 1'b0 || drop_count !== 8'd0)
      $display("FAIL b2b_overrun: ovr=%b drops=%0d want 0 0", overrun, drop_count);
    else passed++;
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    load_ramp(1, 0);
    frame_valid = 1'b1;
    repeat (3) @(negedge clock);
    frame_valid = 1'b0;
    repeat (2) @(negedge clock);
    total++;
    if (overrun !== 1'b1 || drop_count !== 8'd1)
      $display("FAIL ovr_set: ovr=%b drops=%0d want 1 1", overrun, drop_count);
    else passed++;
    overrun_clr = 1'b1;
    @(negedge clock);
    overrun_clr = 1'b0;
    total++;
    if (overrun !== 1'b0 || drop_count !== 8'd0)
      $display("FAIL ovr_clr: ovr=%b drops=%0d want 0 0", overrun, drop_count);
    else passed++;
    frame_valid = 1'b1; overrun_clr = 1'b1;
    @(negedge clock);
    overrun_clr = 1'b0;
    @(negedge clock);
    frame_valid = 1'b0;
    total++;
    if (overrun !== 1'b1 || drop_count !== 8'd2)
      $display("FAIL ovr_set_wins: ovr=%b drops=%0d want 1 2", overrun, drop_count);
    else passed++;
    frame_valid = 1'b1;
    repeat (260) @(negedge clock);
    frame_valid = 1'b0;
    total++;
    if (drop_count !== 8'd255) $display("FAIL ovr_saturate: drops=%0d want 255", drop_count); else passed++;
    overrun_clr = 1'b1;
    @(negedge clock);
    overrun_clr = 1'b0;
    total++;
    if (overrun !== 1'b0 || drop_count !== 8'd0)
      $display("FAIL ovr_clr2: ovr=%b drops=%0d want 0 0", overrun, drop_count);
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit found, residual;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    load_ramp(1, 0);
    out_ready = 1'b1;
    pulse_frame();
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (out_valid && out_band == 4'd7) found = 1'b1;
      else @(negedge clock);
    end
    total++;
    if (!found) $display("FAIL rst_reach_band7: band 7 not seen within 50 cycles"); else passed++;
    #2 reset = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_band !== 4'd0)
      $display("FAIL rst_async: valid=%b band=%0d want 0 0", out_valid, out_band);
    else passed++;
    @(negedge clock);
    reset = 1'b0;
    residual = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (out_valid) residual = 1'b1;
      @(negedge clock);
    end
    total++;
    if (residual) $display("FAIL rst_residual: valid=1 seen after reset, want 0"); else passed++;
    load_ramp(2, 1);
    pulse_frame();
    repeat (2) @(negedge clock);
    total++;
    if (out_valid !== 1'b1 || out_band !== 4'd0 || out_data !== 16'sd1)
      $display("FAIL rst_restart: valid=%b band=%0d data=%0d want 1 0 1", out_valid, out_band, out_data);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_sat();
    test_enable();
    test_backpressure();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
